// File: rtl/pc_next_unit_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pc_pkg
// Shared definitions for the program-counter stage of the single-cycle core:
//   - pc_state_e : BOOT / RUN / TRAP state encoding of the PC sequencer
//   - pc_sel_e   : which candidate becomes the next PC
//   - DEFAULT_RESET_VECTOR / DEFAULT_TRAP_VECTOR : default PC load values
//   - isMisaligned() : instruction-address alignment test (4-byte aligned)
// No ports; imported by pc_next_unit_if, pc_target_calc and pc_next_unit.
// ---------------------------------------------------------------------------
package riscv_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_PC4  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JAL  = 2'd2,
    SEL_JALR = 2'd3
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0040_0100;

  // Without the compressed extension every instruction sits on a 4-byte
  // boundary, so any set bit in the two LSBs of a target is a fault.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// ---------------------------------------------------------------------------
// pc_next_unit_if
// Bundles the control/data inputs and the PC-side outputs of pc_next_unit.
// Parameter N : datapath/address width (must match the unit's N).
// Signals (named from the unit's point of view):
//   stall_i, branch_i, condition_is_true_i, jal_i, jalr_i, trap_ack_i : 1b in
//   imm_i, rs1_data_i                                                : N  in
//   pc_o, pc_plus4_o, epc_o                                          : N  out
//   instr_valid_o, taken_o, trap_o                                   : 1b out
// Modports: slave  = the PC unit itself
//           master = whoever drives the controls (decoder / testbench)
// ---------------------------------------------------------------------------
interface pc_next_unit_if
  import riscv_pc_pkg::*;
#(
  parameter int N = 32
);

  logic         stall_i;
  logic         branch_i;
  logic         condition_is_true_i;
  logic         jal_i;
  logic         jalr_i;
  logic [N-1:0] imm_i;
  logic [N-1:0] rs1_data_i;
  logic         trap_ack_i;
  logic [N-1:0] pc_o;
  logic [N-1:0] pc_plus4_o;
  logic         instr_valid_o;
  logic         taken_o;
  logic         trap_o;
  logic [N-1:0] epc_o;

  modport slave (
    input  stall_i, branch_i, condition_is_true_i, jal_i, jalr_i,
           imm_i, rs1_data_i, trap_ack_i,
    output pc_o, pc_plus4_o, instr_valid_o, taken_o, trap_o, epc_o
  );

  modport master (
    output stall_i, branch_i, condition_is_true_i, jal_i, jalr_i,
           imm_i, rs1_data_i, trap_ack_i,
    input  pc_o, pc_plus4_o, instr_valid_o, taken_o, trap_o, epc_o
  );

endinterface

// File: rtl/pc_next_unit_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Purely combinational target computation for the PC stage.
// Ports:
//   pc_i, imm_i, rs1_data_i            : N  in  current PC and operands
//   branch_i, condition_is_true_i,
//   jal_i, jalr_i                      : 1b in  decoded control transfer
//   br_tgt_o                           : N  out pc + imm (branches and JAL)
//   jr_tgt_o                           : N  out (rs1 + imm) with bit 0 cleared
//   sel_o                              : pc_sel_e out chosen next-PC source
//   misaligned_o                       : 1b out chosen transfer target is not
//                                               4-byte aligned
// All sums wrap modulo 2^N.
// ---------------------------------------------------------------------------
module pc_target_calc
  import riscv_pc_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] pc_i,
  input  logic [N-1:0] imm_i,
  input  logic [N-1:0] rs1_data_i,
  input  logic         branch_i,
  input  logic         condition_is_true_i,
  input  logic         jal_i,
  input  logic         jalr_i,
  output logic [N-1:0] br_tgt_o,
  output logic [N-1:0] jr_tgt_o,
  output pc_sel_e      sel_o,
  output logic         misaligned_o
);

  logic [N-1:0] jrSum;

  assign br_tgt_o = pc_i + imm_i;
  assign jrSum    = rs1_data_i + imm_i;
  assign jr_tgt_o = {jrSum[N-1:1], 1'b0};

  // Pick the next-PC source. JALR beats JAL beats a taken branch; when
  // several controls are raised together the priority simply decides and
  // nothing is flagged.
  always_comb begin
    sel_o = SEL_PC4;
    if (jalr_i) begin
      sel_o = SEL_JALR;
    end else if (jal_i) begin
      sel_o = SEL_JAL;
    end else if (branch_i && condition_is_true_i) begin
      sel_o = SEL_BR;
    end
  end

  // Alignment is only judged on the target that is actually taken, so a
  // not-taken branch with an odd offset can never fault.
  always_comb begin
    misaligned_o = 1'b0;
    case (sel_o)
      SEL_JALR:        misaligned_o = isMisaligned(jr_tgt_o[1:0]);
      SEL_JAL, SEL_BR: misaligned_o = isMisaligned(br_tgt_o[1:0]);
      default:         misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
// Program-counter stage of the single-cycle RISC-V core. Owns the PC
// register, sequences BOOT -> RUN, honours stall, and on a misaligned
// control-transfer target records the faulting PC and parks at TRAP_VECTOR
// until the trap is acknowledged.
// Parameters: N (width), RESET_VECTOR, TRAP_VECTOR.
// Ports:
//   clk           : in  core clock, rising edge
//   reset         : in  synchronous, active-low reset
//   bus           : pc_next_unit_if.slave (controls in, PC/link/trap out)
//   taken_count_o : out [31:0] saturating count of taken transfers
//                   (only present when PC_BRANCH_STATS_EN is defined)
// Optional feature macro: PC_BRANCH_STATS_EN
// ---------------------------------------------------------------------------
module pc_next_unit
  import riscv_pc_pkg::*;
#(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
  parameter logic [N-1:0] TRAP_VECTOR  = N'(DEFAULT_TRAP_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  pc_next_unit_if.slave    bus
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_count_o
`endif
);

  pc_state_e    state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] epc_q, epc_d;

  logic [N-1:0] brTgt;
  logic [N-1:0] jrTgt;
  logic [N-1:0] pcPlus4;
  logic [N-1:0] nextPc;
  pc_sel_e      sel;
  logic         misaligned;
  logic         instrValid;
  logic         taken;

  pc_target_calc #(.N(N)) u_target_calc (
    .pc_i                (pc_q),
    .imm_i               (bus.imm_i),
    .rs1_data_i          (bus.rs1_data_i),
    .branch_i            (bus.branch_i),
    .condition_is_true_i (bus.condition_is_true_i),
    .jal_i               (bus.jal_i),
    .jalr_i              (bus.jalr_i),
    .br_tgt_o            (brTgt),
    .jr_tgt_o            (jrTgt),
    .sel_o               (sel),
    .misaligned_o        (misaligned)
  );

  assign pcPlus4    = pc_q + N'(4);
  assign instrValid = (state_q == RUN);
  assign taken      = instrValid && (sel != SEL_PC4);

  // Turn the select code into the actual next PC. Branches and JAL share
  // the pc+imm adder; everything else falls through to sequential fetch.
  always_comb begin
    nextPc = pcPlus4;
    case (sel)
      SEL_JALR:        nextPc = jrTgt;
      SEL_JAL, SEL_BR: nextPc = brTgt;
      default:         nextPc = pcPlus4;
    endcase
  end

  // Sequencer next-state logic. BOOT spends exactly one cycle with no valid
  // instruction; RUN advances the PC unless stalled, diverting to the trap
  // vector on a misaligned taken target; TRAP waits for the acknowledge.
  // Stall only matters in RUN. pc_q already holds TRAP_VECTOR while in
  // TRAP, so leaving TRAP resumes fetching there without touching the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (!bus.stall_i) begin
          if (taken && misaligned) begin
            epc_d   = pc_q;
            pc_d    = TRAP_VECTOR;
            state_d = TRAP;
          end else begin
            pc_d = nextPc;
          end
        end
      end
      TRAP: begin
        if (bus.trap_ack_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State, PC and exception-PC registers with a synchronous active-low
  // reset that restarts the core from RESET_VECTOR in BOOT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pcPlus4;
  assign bus.instr_valid_o = instrValid;
  assign bus.taken_o       = taken;
  assign bus.trap_o        = (state_q == TRAP);
  assign bus.epc_o         = epc_q;

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] takenCount_q, takenCount_d;

  // Count every control transfer that actually retires, trapping ones
  // included. Stalled cycles do not retire anything, and the counter
  // sticks at all-ones rather than wrapping back to zero.
  always_comb begin
    takenCount_d = takenCount_q;
    if (instrValid && !bus.stall_i && taken && (takenCount_q != 32'hFFFF_FFFF)) begin
      takenCount_d = takenCount_q + 32'd1;
    end
  end

  // Statistics register, cleared together with the rest of the stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      takenCount_q <= '0;
    end else begin
      takenCount_q <= takenCount_d;
    end
  end

  assign taken_count_o = takenCount_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_next_unit
// Self-checking bench for pc_next_unit. Directed scenarios walk through
// boot, branches, JALR priority with a trap, stall, reset during a trap and
// (with PC_BRANCH_STATS_EN) the taken counter; a randomized run follows.
// Every cycle the outputs are compared with a behavioural model of the PC
// stage kept in this file.
// ---------------------------------------------------------------------------
module tb_pc_next_unit;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] TV = 32'h0040_0100;

  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_TRAP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pc_next_unit_if #(.N(32)) bus ();

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] takenCount;
`endif

  pc_next_unit #(.N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PC_BRANCH_STATS_EN
    ,
    .taken_count_o (takenCount)
`endif
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  // Behavioural model state.
  int          modelMode  = MODE_BOOT;
  logic [31:0] modelPc    = RV;
  logic [31:0] modelEpc   = '0;
  logic [31:0] modelCount = '0;

  // A control transfer happens when an instruction is live and any of the
  // jump/branch-taken conditions hold.
  function automatic logic modelTaken();
    return (modelMode == MODE_RUN) &&
           (bus.jalr_i || bus.jal_i || (bus.branch_i && bus.condition_is_true_i));
  endfunction

  // Target chosen by the priority rule, with plain 32-bit wrapping sums.
  function automatic logic [31:0] modelTarget();
    if (bus.jalr_i) return (bus.rs1_data_i + bus.imm_i) & 32'hFFFF_FFFE;
    if (bus.jal_i || (bus.branch_i && bus.condition_is_true_i)) return modelPc + bus.imm_i;
    return modelPc + 32'd4;
  endfunction

  task automatic checkSignal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                               input logic cnd, input logic jl, input logic jlr,
                               input logic [31:0] imm, input logic [31:0] rs1,
                               input logic ack);
    reset                   = rst;
    bus.stall_i             = stl;
    bus.branch_i            = br;
    bus.condition_is_true_i = cnd;
    bus.jal_i               = jl;
    bus.jalr_i              = jlr;
    bus.imm_i               = imm;
    bus.rs1_data_i          = rs1;
    bus.trap_ack_i          = ack;
    #2;
  endtask

  task automatic checkOutput();
    checkSignal("pc", bus.pc_o, modelPc);
    checkSignal("pc_plus4", bus.pc_plus4_o, modelPc + 32'd4);
    checkSignal("instr_valid", 32'(bus.instr_valid_o), 32'(modelMode == MODE_RUN));
    checkSignal("trap", 32'(bus.trap_o), 32'(modelMode == MODE_TRAP));
    checkSignal("epc", bus.epc_o, modelEpc);
    checkSignal("taken", 32'(bus.taken_o), 32'(modelTaken()));
`ifdef PC_BRANCH_STATS_EN
    checkSignal("taken_count", takenCount, modelCount);
`endif
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic        tk;
    logic [31:0] tgt;
    @(posedge clk);
    tk  = modelTaken();
    tgt = modelTarget();
    if (!reset) begin
      modelMode  = MODE_BOOT;
      modelPc    = RV;
      modelEpc   = '0;
      modelCount = '0;
    end else if (modelMode == MODE_BOOT) begin
      modelMode = MODE_RUN;
    end else if (modelMode == MODE_RUN) begin
      if (!bus.stall_i) begin
        if (tk && modelCount != 32'hFFFF_FFFF) modelCount = modelCount + 32'd1;
        if (tk && (tgt % 4) != 0) begin
          modelEpc  = modelPc;
          modelPc   = TV;
          modelMode = MODE_TRAP;
        end else begin
          modelPc = tgt;
        end
      end
    end else begin
      if (bus.trap_ack_i) modelMode = MODE_RUN;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rImm;
    logic [31:0] rRs1;

    // Reset for two edges, then check reset values.
    applyStimulus(1'b0, 0, 0, 0, 0, 0, '0, '0, 0);
    tick();
    tick();
    checkOutput();
    checkSignal("reset_pc", bus.pc_o, RV);
    checkSignal("reset_valid", 32'(bus.instr_valid_o), 32'd0);
    checkSignal("reset_epc", bus.epc_o, 32'd0);

    // Release reset: one BOOT cycle, then sequential fetch.
    applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 0);
    checkOutput();
    tick();
    checkSignal("boot_done_valid", 32'(bus.instr_valid_o), 32'd1);
    checkSignal("boot_done_pc", bus.pc_o, RV);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 0);
      checkOutput();
      tick();
      checkSignal("seq_pc", bus.pc_o, RV + 32'(4 * k));
    end

    // Taken backward branch from 0x0040_0010.
    applyStimulus(1'b1, 0, 1, 1, 0, 0, 32'hFFFF_FFF8, '0, 0);
    checkOutput();
    checkSignal("br_taken_flag", 32'(bus.taken_o), 32'd1);
    tick();
    checkSignal("br_taken_pc", bus.pc_o, 32'h0040_0008);

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 0);
      checkOutput();
      tick();
    end
    checkSignal("back_at_10", bus.pc_o, 32'h0040_0010);

    // Same branch, condition false.
    applyStimulus(1'b1, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, '0, 0);
    checkOutput();
    checkSignal("br_nt_flag", 32'(bus.taken_o), 32'd0);
    tick();
    checkSignal("br_nt_pc", bus.pc_o, 32'h0040_0014);

    // Not-taken branch with a misaligned offset must not trap.
    applyStimulus(1'b1, 0, 1, 0, 0, 0, 32'd3, '0, 0);
    checkOutput();
    tick();
    checkSignal("nt_misaligned_pc", bus.pc_o, 32'h0040_0018);
    checkSignal("nt_misaligned_trap", 32'(bus.trap_o), 32'd0);

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 0);
      checkOutput();
      tick();
    end

    // JALR wins over JAL and branch; target 0x0040_1002 is misaligned.
    applyStimulus(1'b1, 0, 1, 1, 1, 1, 32'd0, 32'h0040_1003, 0);
    checkOutput();
    checkSignal("jalr_taken", 32'(bus.taken_o), 32'd1);
    checkSignal("jalr_link", bus.pc_plus4_o, 32'h0040_0024);
    tick();
    checkSignal("trap_flag", 32'(bus.trap_o), 32'd1);
    checkSignal("trap_epc", bus.epc_o, 32'h0040_0020);
    checkSignal("trap_pc", bus.pc_o, TV);
    checkSignal("trap_valid", 32'(bus.instr_valid_o), 32'd0);

    // Trap holds without acknowledge, stall ignored.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, k[0], 0, 0, 1, 0, 32'd8, '0, 0);
      checkOutput();
      tick();
      checkSignal("trap_hold", 32'(bus.trap_o), 32'd1);
    end
    applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 1);
    checkOutput();
    tick();
    checkSignal("ack_valid", 32'(bus.instr_valid_o), 32'd1);
    checkSignal("ack_pc", bus.pc_o, TV);
    checkSignal("ack_trap", 32'(bus.trap_o), 32'd0);

    // Stalled JAL holds the PC, then takes it on release.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1, 0, 0, 1, 0, 32'd16, '0, 0);
      checkOutput();
      tick();
      checkSignal("stall_pc", bus.pc_o, TV);
    end
    applyStimulus(1'b1, 0, 0, 0, 1, 0, 32'd16, '0, 0);
    checkOutput();
    tick();
    checkSignal("stall_release_pc", bus.pc_o, TV + 32'd16);

    // Enter a trap via JAL +2, then reset while trapped.
    applyStimulus(1'b1, 0, 0, 0, 1, 0, 32'd2, '0, 0);
    checkOutput();
    tick();
    checkSignal("jal_trap", 32'(bus.trap_o), 32'd1);
    checkSignal("jal_trap_epc", bus.epc_o, TV + 32'd16);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, '0, '0, 0);
    checkOutput();
    tick();
    checkSignal("rst_trap_pc", bus.pc_o, RV);
    checkSignal("rst_trap_flag", 32'(bus.trap_o), 32'd0);
    checkSignal("rst_trap_epc", bus.epc_o, 32'd0);
    checkSignal("rst_trap_valid", 32'(bus.instr_valid_o), 32'd0);

    // Counter scenario: 5 taken, 3 not taken, 2 stalled taken.
    applyStimulus(1'b1, 0, 0, 0, 0, 0, '0, '0, 0);
    checkOutput();
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k < 5)      applyStimulus(1'b1, 0, 0, 0, 1, 0, 32'd8, '0, 0);
      else if (k < 8) applyStimulus(1'b1, 0, 1, 0, 0, 0, 32'd8, '0, 0);
      else            applyStimulus(1'b1, 1, 0, 0, 1, 0, 32'd8, '0, 0);
      checkOutput();
      tick();
    end
    checkSignal("after_counter_pc", bus.pc_o, RV + 32'd40 + 32'd12);
`ifdef PC_BRANCH_STATS_EN
    checkSignal("count_five", takenCount, 32'd5);
    force dut.takenCount_q = 32'hFFFF_FFFF;
    #1;
    release dut.takenCount_q;
    modelCount = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 0, 0, 0, 1, 0, 32'd8, '0, 0);
    checkOutput();
    tick();
    checkSignal("count_saturate", takenCount, 32'hFFFF_FFFF);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      rImm = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 1) == 1) rImm = -rImm;
      rRs1 = ($urandom_range(0, 4) == 0) ? $urandom : (RV + ($urandom & 32'h0000_3FFC));
      applyStimulus(($urandom_range(0, 40) != 0),
                    ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0),
                    rImm, rRs1,
                    ($urandom_range(0, 2) == 0));
      checkOutput();
      tick();
    end
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage directly downstream of the branch condition block in the single-cycle RISC-V core.
- Consumes `condition_is_true_i` together with the decoded jump/branch controls and computes the next PC.
- Owns the PC register, handles stall, and detects instruction-address-misaligned targets.
- On a misaligned target it enters a trap handshake before resuming at `TRAP_VECTOR`.
- Drives the instruction memory address and the link value (PC+4) used by JAL/JALR writeback.

Parameters:
- `N`, 32, datapath/address width.
- `RESET_VECTOR`, 32'h0040_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0040_0100, PC value loaded when a misaligned target is taken.

Ports:
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall_i`  in  1  hold PC and state this cycle.
- `branch_i`  in  1  current instruction is a conditional branch.
- `condition_is_true_i`  in  1  branch condition result from branch control.
- `jal_i`  in  1  current instruction is JAL.
- `jalr_i`  in  1  current instruction is JALR.
- `imm_i`  in  N  sign-extended immediate (B/J/I type as decoded).
- `rs1_data_i`  in  N  rs1 operand for JALR.
- `trap_ack_i`  in  1  trap handler/bench acknowledges trap.
- `pc_o`  out  N  current PC (instruction memory address).
- `pc_plus4_o`  out  N  `pc_o`+4, link value.
- `instr_valid_o`  out  1  `pc_o` addresses an instruction to execute this cycle.
- `taken_o`  out  1  control transfer taken this cycle (combinational).
- `trap_o`  out  1  misaligned-target trap pending.
- `epc_o`  out  N  PC of faulting instruction.

Behaviour:
- Reset: one clock, synchronous, active-low. Reset is sampled on the `clk` edge; `reset`=0 forces BOOT on that edge.
- Reset values:
  - `pc_o`=`RESET_VECTOR`, `epc_o`=0, `trap_o`=0, `instr_valid_o`=0.
  - state=BOOT; stats counter (if enabled)=0.
- FSM states BOOT, RUN, TRAP (2-bit encoding in package):
  - BOOT: `instr_valid_o`=0, PC held. Next cycle goes to RUN unconditionally; `stall_i` is ignored.
  - RUN: `instr_valid_o`=1. If `stall_i`=1, PC and state hold and the control inputs are ignored. Otherwise PC <= next_pc, or trap entry if misaligned.
  - TRAP: `instr_valid_o`=0, `trap_o`=1, `pc_o`=`TRAP_VECTOR`. `trap_ack_i`=1 -> RUN next cycle with `trap_o`=0. `stall_i` is ignored in TRAP.
- Target computation, all N-bit modulo 2^N, wrap-around silently allowed:
  - br_tgt = `pc_o`+`imm_i` (used for branches and JAL).
  - jr_tgt = (`rs1_data_i`+`imm_i`) & ~1.
- Select priority: `jalr_i` > `jal_i` > (`branch_i` & `condition_is_true_i`) > `pc_o`+4.
- `taken_o` = `instr_valid_o` & (`jalr_i` | `jal_i` | (`branch_i` & `condition_is_true_i`)).
- Misaligned: `taken_o` & (selected target[1:0] != 0). On that edge in RUN with no stall:
  - `epc_o` <= `pc_o`, PC <= `TRAP_VECTOR`, state <= TRAP.
  - The link value is still presented this cycle.
  - Writeback suppression is the caller's concern, not this block's.
- Not-taken branches never trap, whatever the target.
- Multiple control inputs asserted together: priority above applies. No error is flagged.
- `pc_plus4_o` is combinational from `pc_o`.
- Latency: the new PC is visible one clock after the deciding cycle.

Optional Feature:
- Macro: `PC_BRANCH_STATS_EN`.
- Defined:
  - Adds output `taken_count_o` [31:0].
  - Increments on every RUN, non-stalled cycle with `taken_o`=1, including trapping transfers.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package `riscv_pc_pkg`:
  - FSM state encoding (BOOT=2'd0, RUN=2'd1, TRAP=2'd2).
  - Default `RESET_VECTOR` and `TRAP_VECTOR` constants.
  - Next-PC select encoding (SEL_PC4, SEL_BR, SEL_JAL, SEL_JALR).
- One sub-module, `pc_target_calc` (combinational):
  - Computes br_tgt and jr_tgt, the select code and the misaligned flag.
  - The top keeps the PC register, the FSM, the epc and the stats logic.

Test Plan:
- Reset and boot: release reset -> `pc_o`=32'h0040_0000, `instr_valid_o`=0 for 1 cycle. Then 3 plain cycles -> `pc_o` = ..._0004, ..._0008, ..._000C.
- Branch with `imm_i`=32'hFFFF_FFF8 at `pc_o`=32'h0040_0010:
  - `branch_i`=1, `condition_is_true_i`=1 -> `taken_o`=1, next `pc_o`=32'h0040_0008.
  - Same with condition=0 -> next `pc_o`=32'h0040_0014, `taken_o`=0.
- JALR priority at `pc_o`=32'h0040_0020, `rs1_data_i`=32'h0040_1003, `imm_i`=0:
  - `jalr_i`=`jal_i`=`branch_i`=1, condition=1 -> next `pc_o`=32'h0040_1002. This traps (bit1=1).
  - Then `trap_o`=1, `epc_o`=32'h0040_0020, `pc_o`=32'h0040_0100.
  - `trap_o` holds until `trap_ack_i`; the cycle after ack -> `instr_valid_o`=1, `pc_o`=32'h0040_0100.
- Stall during taken JAL: `stall_i`=1 for 2 cycles with `jal_i`=1, `imm_i`=16 -> `pc_o` unchanged. Release -> `pc_o` += 16.
- Reset mid-TRAP: assert reset while `trap_o`=1 -> next edge `pc_o`=`RESET_VECTOR`, `trap_o`=0, `epc_o`=0, state BOOT.
- With `PC_BRANCH_STATS_EN`: 5 taken, 3 not-taken, 2 stalled-taken cycles -> `taken_count_o`=5. Preload saturation via force at 32'hFFFF_FFFF plus one taken -> stays 32'hFFFF_FFFF.
